// File: rtl/rt_status_avalon.sv
// rt_status_avalon: Avalon-MM status/readback slave that times raytracer runs and tracks completion.
// One-cycle read latency, sticky done/overrun flags with W1C clear, registered level irq.
module rt_status_avalon #(
    parameter logic [31:0] BLOCK_ID = 32'h5254_0001,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_s0_address,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    input  logic        start_rt,
    input  logic        done_rt,
    output logic        irq
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             state_q, state_d;
    logic               done_q, done_d, ovr_q, ovr_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic               rvalid_q, rvalid_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d, cyc_inc;
    logic [31:0]        runs_q, runs_d, rdata_q, rdata_d, reg_val;
    logic               wr_ctl;
    always_comb begin
        cyc_inc  = &cycles_q ? cycles_q : cycles_q + 1'b1;
        wr_ctl   = avs_s0_write && !avs_s0_read && avs_s0_address == 2'd0;
        state_d  = state_q;
        cycles_d = cycles_q;
        runs_d   = runs_q;
        done_d   = done_q && !(wr_ctl && avs_s0_writedata[1]);
        ovr_d    = ovr_q && !(wr_ctl && avs_s0_writedata[2]);
        irq_en_d = wr_ctl ? avs_s0_writedata[3] : irq_en_q;
        irq_d    = done_q && irq_en_q;
        if (state_q == IDLE) begin
            if (start_rt) begin
                state_d  = BUSY;
                cycles_d = '0;
            end
        end else begin
            // A coincident start restarts timing; the finished run's final count is dropped.
            cycles_d = (start_rt && done_rt) ? '0 : cyc_inc;
            if (done_rt) begin
                done_d  = 1'b1;
                runs_d  = runs_q + 32'd1;
                state_d = start_rt ? BUSY : IDLE;
            end else if (start_rt) begin
                ovr_d = 1'b1;
            end
        end
        reg_val  = avs_s0_address == 2'd0 ? {28'd0, irq_en_q, ovr_q, done_q, state_q == BUSY} :
                   avs_s0_address == 2'd1 ? 32'(cycles_q) :
                   avs_s0_address == 2'd2 ? runs_q : BLOCK_ID;
        rdata_d  = avs_s0_read ? reg_val : rdata_q;
        rvalid_d = avs_s0_read;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            cycles_q <= '0;
            runs_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            cycles_q <= cycles_d;
            runs_q   <= runs_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
    assign avs_s0_readdata      = rdata_q;
    assign avs_s0_readdatavalid = rvalid_q;
    assign irq                  = irq_q;
endmodule

// File: tb/tb_rt_status_avalon.sv
// tb_rt_status_avalon: directed and random checks of rt_status_avalon against a run-level model.
module tb_rt_status_avalon;
    localparam logic [31:0] ID = 32'h5254_0001;
    logic        clk = 0, reset = 0;
    logic [1:0]  address = 0;
    logic        read = 0, write = 0, start_rt = 0, done_rt = 0;
    logic [31:0] writedata = 0;
    logic [31:0] rd, rd4;
    logic        rv, rv4, irq, irq4;
    int          n_asserts = 0, n_fail = 0;
    bit          m_busy, m_done, m_ovr, m_irqen, m_irq, m_rv;
    longint      m_cnt;
    logic [31:0] m_runs, m_rd, m_rd4;

    rt_status_avalon dut (.clk(clk), .reset(reset), .avs_s0_address(address), .avs_s0_read(read),
        .avs_s0_readdata(rd), .avs_s0_readdatavalid(rv), .avs_s0_write(write),
        .avs_s0_writedata(writedata), .start_rt(start_rt), .done_rt(done_rt), .irq(irq));
    rt_status_avalon #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .avs_s0_address(address),
        .avs_s0_read(read), .avs_s0_readdata(rd4), .avs_s0_readdatavalid(rv4), .avs_s0_write(write),
        .avs_s0_writedata(writedata), .start_rt(start_rt), .done_rt(done_rt), .irq(irq4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] regval(input logic [1:0] a, input int w);
        longint mx = (longint'(1) << w) - 1;
        case (a)
            2'd0:    return {28'd0, m_irqen, m_ovr, m_done, m_busy};
            2'd1:    return 32'(m_cnt > mx ? mx : m_cnt);
            2'd2:    return m_runs;
            default: return ID;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_ovr = 0; m_irqen = 0; m_irq = 0; m_rv = 0;
        m_cnt = 0; m_runs = 0; m_rd = 0; m_rd4 = 0;
    endtask

    task automatic step(input bit r, input logic [1:0] a, input bit w, input logic [31:0] wd,
                        input bit s, input bit d);
        bit wok;
        read = r; address = a; write = w; writedata = wd; start_rt = s; done_rt = d;
        m_rv = r;
        if (r) begin
            m_rd  = regval(a, 32);
            m_rd4 = regval(a, 4);
        end
        m_irq = m_done & m_irqen;
        wok = w && !r && a == 2'd0;
        if (wok && wd[1]) m_done = 0;
        if (wok && wd[2]) m_ovr = 0;
        if (wok) m_irqen = wd[3];
        if (!m_busy) begin
            if (s) begin m_busy = 1; m_cnt = 0; end
        end else if (d) begin
            m_done = 1; m_runs++;
            m_cnt = s ? 0 : m_cnt + 1;
            m_busy = s;
        end else begin
            if (s) m_ovr = 1;
            m_cnt++;
        end
        @(posedge clk); #1;
        chk("rvalid", rv, m_rv);
        chk("rdata", rd, m_rd);
        chk("irq", irq, m_irq);
        chk("rvalid4", rv4, m_rv);
        chk("rdata4", rd4, m_rd4);
        chk("irq4", irq4, m_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    task automatic rdreg(input logic [1:0] a);
        step(1, a, 0, 0, 0, 0);
    endtask
    task automatic wrctl(input logic [31:0] wd);
        step(0, 0, 1, wd, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", rv, 0);
        chk("rst_rdata", rd, 0);
        chk("rst_irq", irq, 0);
        reset = 1;
        rdreg(3);
        chk("id", rd, ID);
        // 100-cycle run
        step(0, 0, 0, 0, 1, 0);
        idle(99);
        step(0, 0, 0, 0, 0, 1);
        rdreg(1); chk("cycles100", rd, 100); chk("cycles_sat4", rd4, 15);
        rdreg(2); chk("runs1", rd, 1);
        rdreg(0); chk("status_done", rd, 32'h2);
        wrctl(32'h2);
        rdreg(0); chk("status_clr", rd, 32'h0);
        // irq enable and clear
        wrctl(32'h8);
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1); chk("irq_lag", irq, 0);
        idle(1);                chk("irq_set", irq, 1);
        wrctl(32'hA);           chk("irq_hold", irq, 1);
        idle(1);                chk("irq_clr", irq, 0);
        // done coincident with W1C: set wins
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        step(0, 0, 1, 32'hA, 0, 1);
        rdreg(0); chk("set_wins", rd, 32'hA);
        rdreg(2); chk("runs3", rd, 3);
        // async reset mid-run
        step(0, 0, 0, 0, 1, 0);
        idle(6);
        rdreg(1); chk("cyc_pre", rd, 6);
        chk("pre_rst_irq", irq, 1);
        #2 reset = 0;
        #1;
        chk("async_rvalid", rv, 0);
        chk("async_rdata", rd, 0);
        chk("async_irq", irq, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1;
        rdreg(3); chk("id_after_rst", rd, ID);
        rdreg(0); chk("status_after_rst", rd, 0);
        rdreg(1); chk("cycles_after_rst", rd, 0);
        // overrun: restart at +5, done at +20
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0);
        idle(14);
        step(0, 0, 0, 0, 0, 1);
        rdreg(1); chk("cycles20", rd, 20);
        rdreg(0); chk("overrun", rd, 32'h6);
        // back-to-back start+done, then ordered consecutive reads
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 1);
        rdreg(0); chk("b2b_status", rd, 32'h7);
        rdreg(1); chk("b2b_cycles", rd, 1);
        rdreg(2); chk("b2b_runs", rd, 2);
        rdreg(3); chk("b2b_id", rd, ID);
        step(1, 2, 0, 0, 0, 1); chk("pre_update", rd, 2);
        rdreg(2); chk("post_update", rd, 3);
        step(0, 0, 0, 0, 0, 1);
        rdreg(2); chk("idle_done_runs", rd, 3);
        rdreg(0); chk("idle_done_status", rd, 32'h6);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                 $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/rt_status_avalon.md
Name: rt_status_avalon

Overview:
- Avalon-MM slave read path and completion tracker for the raytracer; the read-side counterpart of the start-command write slave.
- Observes the start_rt pulse and the raytracer's done_rt pulse.
- Times each run and holds sticky completion/overrun flags.
- Returns status to the HPS over Avalon reads with a fixed one-cycle read latency; raises an optional level interrupt on completion.

Parameters:
- BLOCK_ID, 32'h5254_0001, constant returned at address 3.
- CNT_W, 32, width of the cycle counter (≤32; zero-extended on read).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- avs_s0_address  in  2  word address
- avs_s0_read  in  1  read strobe
- avs_s0_readdata  out  32  read data
- avs_s0_readdatavalid  out  1  read data valid
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  32  write data
- start_rt  in  1  one-cycle run-start pulse
- done_rt  in  1  one-cycle run-complete pulse from raytracer
- irq  out  1  level interrupt to HPS

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, done, overrun, irq_en, cycles, runs all 0.
  - readdata=0, readdatavalid=0, irq=0.
- No waitrequest. Every read is accepted in its cycle.
- Reads and writes in the same cycle are not issued by the master. If both are asserted, the read is serviced and the write is ignored.
- State machine IDLE/BUSY, evaluated on each rising edge:
  - IDLE, start_rt=1 → BUSY; cycles←0.
  - IDLE, done_rt=1 → ignored; no flag changes.
  - BUSY, done_rt=0, start_rt=0 → cycles←sat(cycles+1).
  - BUSY, done_rt=1, start_rt=0 → IDLE; cycles←sat(cycles+1); done←1; runs←runs+1 (wraps mod 2^32).
  - BUSY, start_rt=1, done_rt=0 → overrun←1; counter continues (cycles+1); stays BUSY.
  - BUSY, done_rt=1, start_rt=1 → run completes and a new run starts back-to-back.
    - done←1; runs+1; state stays BUSY; cycles←0.
    - The final count of the completed run is lost; overrun is not set.
- Counting: start accepted at edge t, done at edge t+N → cycles reads N. Saturates at 2^CNT_W−1, no wrap.
- busy = (state==BUSY).
- Register map (read):
  - addr0 STATUS: bit0 busy, bit1 done, bit2 overrun, bit3 irq_en, bits31:4 = 0.
  - addr1 CYCLES: current/last cycle count.
  - addr2 RUNS: completed run count.
  - addr3 ID: BLOCK_ID.
- Read timing:
  - Read in cycle t → readdatavalid=1 for exactly cycle t+1 with readdata captured from register values before edge t's updates.
  - Back-to-back reads give one valid per cycle.
  - When readdatavalid=0, readdata holds its last value.
- Write (addr0 only; other addresses ignored):
  - writedata bit1=1 clears done (W1C); bit2=1 clears overrun (W1C).
  - bit3 written directly to irq_en.
  - Other bits ignored.
- Collisions:
  - Hardware set of done/overrun in the same cycle as W1C clear → set wins (flag stays 1).
- irq registered: irq ← done & irq_en; it appears one cycle after the condition.
- A subsequent run leaves done set until software clears it.

Test Plan:
- Reset mid-BUSY (cycles=7): assert reset=0 asynchronously → busy, cycles, irq, readdatavalid drop to 0 before next edge. After release, read addr3 → 32'h5254_0001 one cycle after read.
- start_rt at edge t, done_rt at edge t+100 → read addr1 = 100, addr2 = 1. addr0 = 0x2, then write 0x2 to addr0 → addr0 reads 0x0.
- Write 0x8 to addr0, then start/done run → irq=1 one cycle after done sets. Write 0x2 → irq=0 one cycle after done clears. Done pulse coincident with W1C write → done stays 1.
- start_rt again while BUSY at cycle 5, done at 20 → overrun bit set, cycles=20. Start+done same cycle → runs increments, busy remains 1, cycles restarts at 0. done_rt while IDLE → no change.
- Force CNT_W=4, run for 20 cycles → cycles reads 15 (saturated).
- Reads on consecutive cycles to addr0..3 → four consecutive readdatavalid cycles with the correct ordered data. Read with simultaneous hardware update → returns pre-update value.
